// File: rtl/mmio_io_ctrl.sv
// MMIO controller for addresses 0xFB-0xFF: debounced pushbutton state
// register plus four raw 7-segment digit registers scanned onto the display.
module mmio_io_ctrl #(
  parameter int DEB_CYCLES   = 16,
  parameter int SCAN_CYCLES  = 1024,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic       sel,
  output logic [7:0] rdata,
  input  logic [2:0] pb_in,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int SW = $clog2(SCAN_CYCLES);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    pb_state;
  logic [DW-1:0] deb_cnt [3];
  logic [7:0]    digit [4];
  logic [SW-1:0] slot_cnt;
  logic [1:0]    idx;
  logic          digit_hit;

  assign digit_hit = (addr[7:2] == 6'h3F);

  // Two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pb_in;
      sync2 <= sync1;
    end
  end

  // Per-button debouncer: accept a change only after it has been stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb_state <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == pb_state[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          pb_state[i] <= ~pb_state[i];
          deb_cnt[i]  <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // CPU stores into the digit registers; 0xFB and below are read-only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) digit[i] <= 8'hFF;
    end else if (we && digit_hit) begin
      digit[addr[1:0]] <= wdata;
    end
  end

  // Slot timer and digit index for the display scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == SW'(SCAN_CYCLES - 1)) begin
      slot_cnt <= '0;
      idx      <= idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Registered display drive: blank at slot start, then light one digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else if (slot_cnt < SW'(BLANK_CYCLES)) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= digit[idx];
    end
  end

  assign sel = (addr >= 8'hFB);

  // Combinational read mux over the owned address window
  always_comb begin
    rdata = 8'h00;
    if (addr == 8'hFB) begin
      rdata = {5'b0, pb_state};
    end else if (digit_hit) begin
      rdata = digit[addr[1:0]];
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl with short debounce and scan periods.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_mmio_io_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       we = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       sel;
  logic [7:0] rdata;
  logic [2:0] pb_in = 3'b000;
  logic [7:0] seg;
  logic [3:0] an;

  int tests = 0;
  int fails = 0;

  mmio_io_ctrl #(
    .DEB_CYCLES(4),
    .SCAN_CYCLES(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .we(we),
    .wdata(wdata),
    .sel(sel),
    .rdata(rdata),
    .pb_in(pb_in),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a,
                        input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait for the first cycle where an switches to pattern t
  task automatic wait_first(input logic [3:0] t);
    logic [3:0] prev;
    bit ok;
    ok = 1'b0;
    prev = an;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (an == t && prev != t) begin
        ok = 1'b1;
        break;
      end
      prev = an;
    end
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL sync_an_%b: observed timeout expected transition", t);
    end
  endtask

  logic [7:0] dig [4];
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  int s;
  int p;

  initial begin
    dig[0] = 8'hC0;
    dig[1] = 8'hF9;
    dig[2] = 8'hA4;
    dig[3] = 8'hB0;

    // power-on reset
    #1 rst = 1'b1;
    #2;
    chk("por_an", {4'h0, an}, 8'h0F);
    chk("por_seg", seg, 8'hFF);
    chk_rd("por_pb", 8'hFB, 8'h00);
    chk_rd("por_dig0", 8'hFC, 8'hFF);
    chk_rd("por_dig3", 8'hFF, 8'hFF);
    tick();
    rst = 1'b0;
    tick();

    // debounce latency: 2 sync + 4 stable edges
    addr  = 8'hFB;
    pb_in = 3'b010;
    ticks(5);
    chk("deb_edge5", rdata, 8'h00);
    tick();
    chk("deb_edge6", rdata, 8'h02);
    ticks(14);
    chk("deb_hold20", rdata, 8'h02);
    pb_in = 3'b000;
    ticks(8);
    chk("deb_release", rdata, 8'h00);

    // 3-cycle glitches on the right button are rejected
    for (int k = 0; k < 3; k++) begin
      pb_in = 3'b100;
      ticks(3);
      pb_in = 3'b000;
      ticks(3);
      chk("glitch", rdata, 8'h00);
    end
    ticks(8);
    chk("glitch_end", rdata, 8'h00);

    // two buttons together, then release only the left one
    pb_in = 3'b110;
    ticks(5);
    chk("both_edge5", rdata, 8'h00);
    tick();
    chk("both_edge6", rdata, 8'h06);
    pb_in = 3'b100;
    ticks(5);
    chk("rel1_edge5", rdata, 8'h06);
    tick();
    chk("rel1_edge6", rdata, 8'h04);

    // asynchronous reset in the middle of a lit slot
    wait_first(4'b1110);
    chk("pre_rst_an", {4'h0, an}, 8'h0E);
    pb_in = 3'b000;
    #1 rst = 1'b1;
    #1;
    chk("async_an", {4'h0, an}, 8'h0F);
    chk("async_seg", seg, 8'hFF);
    chk_rd("async_pb", 8'hFB, 8'h00);
    rst = 1'b0;
    tick();
    chk("post_rst_e1", {4'h0, an}, 8'h0F);
    tick();
    chk("post_rst_e2", {4'h0, an}, 8'h0F);
    tick();
    chk("post_rst_e3", {4'h0, an}, 8'h0E);

    // register writes and reads
    wr(8'hFC, 8'hC0);
    wr(8'hFD, 8'hF9);
    wr(8'hFE, 8'hA4);
    wr(8'hFF, 8'hB0);
    chk_rd("rd_fc", 8'hFC, 8'hC0);
    chk_rd("rd_fd", 8'hFD, 8'hF9);
    chk_rd("rd_fe", 8'hFE, 8'hA4);
    chk_rd("rd_ff", 8'hFF, 8'hB0);
    wr(8'hFB, 8'h55);
    chk_rd("rd_fb_ro", 8'hFB, 8'h00);
    chk_rd("rd_fc_keep", 8'hFC, 8'hC0);
    chk_rd("rd_ff_keep", 8'hFF, 8'hB0);
    wr(8'hF8, 8'h12);
    chk_rd("rd_fc_low", 8'hFC, 8'hC0);
    chk_rd("rd_10", 8'h10, 8'h00);
    chk("sel_10", {7'h0, sel}, 8'h00);
    chk_rd("rd_fa", 8'hFA, 8'h00);
    chk("sel_fa", {7'h0, sel}, 8'h00);
    addr = 8'hFB;
    #1;
    chk("sel_fb", {7'h0, sel}, 8'h01);
    addr = 8'hFF;
    #1;
    chk("sel_ff", {7'h0, sel}, 8'h01);

    // scan: from first lit cycle of digit 0, two full refresh periods
    wait_first(4'b1110);
    for (int j = 0; j < 64; j++) begin
      if (j > 0) tick();
      s = (j / 8) % 4;
      p = j % 8;
      if (p < 6) begin
        exp_an  = ~(4'b0001 << s);
        exp_seg = dig[s];
      end else begin
        exp_an  = 4'b1111;
        exp_seg = 8'hFF;
      end
      chk($sformatf("scan_an_%0d", j), {4'h0, an}, {4'h0, exp_an});
      chk($sformatf("scan_seg_%0d", j), seg, exp_seg);
    end

    // live update of digit 2 while it is lit
    wait_first(4'b1011);
    wr(8'hFE, 8'h80);
    chk("same_edge_seg", seg, 8'hA4);
    tick();
    chk("live_seg", seg, 8'h80);
    chk("live_an", {4'h0, an}, 8'h0B);
    chk_rd("live_fc", 8'hFC, 8'hC0);
    chk_rd("live_fd", 8'hFD, 8'hF9);
    chk_rd("live_fe", 8'hFE, 8'h80);
    chk_rd("live_ff", 8'hFF, 8'hB0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
